// File: rtl/r5_fft_pkg.sv
// Shared types and constants for the radix-5 SDF FFT stage controllers.
package r5_fft_pkg;

  localparam int PHASE_W   = 3;
  localparam int DEPTH_DEF = 25;
  localparam logic [PHASE_W-1:0] PHASE_LAST = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } r5_state_e;

  function automatic int tw_width(input int depth);
    return $clog2(5 * depth);
  endfunction

endpackage

// File: rtl/r5_sdf_ctrl_if.sv
// Control bus between an SDF stage controller and its datapath / upstream source.
interface r5_sdf_ctrl_if
  import r5_fft_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TWAW  = tw_width(DEPTH)
);
  localparam int IDXW = $clog2(DEPTH);

  // in_valid is a push with no back-pressure: the sample is consumed on every
  // rising edge where shift_en=1; out_valid qualifies the stage output in that same cycle.
  logic               in_valid;
  logic               flush;
  logic               shift_en;
  logic [PHASE_W-1:0] phase;
  logic               bf_en;
  logic               zero_ins;
  logic [TWAW-1:0]    tw_addr;
  logic               out_valid;
  logic               busy;
  logic [IDXW-1:0]    idx;
  r5_state_e          state;

  modport slave (
    input  in_valid, flush,
    output shift_en, phase, bf_en, zero_ins, tw_addr, out_valid, busy, idx, state
  );

  modport master (
    output in_valid, flush,
    input  shift_en, phase, bf_en, zero_ins, tw_addr, out_valid, busy, idx, state
  );

endinterface

// File: rtl/r5_mod_counter.sv
// Sample index (0..DEPTH-1) and phase (0..4) wrap counter for one SDF stage.
module r5_mod_counter
  import r5_fft_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic [PHASE_W-1:0]       phase,
  output logic                     idx_wrap,
  output logic                     phase_wrap
);

  localparam int IDXW = $clog2(DEPTH);

  assign idx_wrap   = (idx == IDXW'(DEPTH - 1));
  assign phase_wrap = (phase == PHASE_LAST);

  // clr wins over en so the final flush step lands on a clean idx/phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      phase <= '0;
    end else if (clr) begin
      idx   <= '0;
      phase <= '0;
    end else if (en) begin
      if (idx_wrap) begin
        idx   <= '0;
        phase <= phase_wrap ? '0 : phase + PHASE_W'(1);
      end else begin
        idx   <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: rtl/r5_sdf_ctrl.sv
// Radix-5 single-delay-feedback stage controller: fill/run/flush sequencing and
// twiddle addressing. Twiddle generator is built only when R5_SDF_CTRL_TW_EN is defined.
module r5_sdf_ctrl
  import r5_fft_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TWAW  = tw_width(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  r5_sdf_ctrl_if.slave bus
);

  localparam int IDXW      = $clog2(DEPTH);
  localparam int FLUSH_LEN = 4 * DEPTH;
  localparam int FCW       = $clog2(FLUSH_LEN);

  r5_state_e          state, state_nxt;
  logic               advance;
  logic               cnt_clr;
  logic               idx_wrap, phase_wrap;
  logic               flush_last;
  logic [IDXW-1:0]    idx;
  logic [PHASE_W-1:0] phase;
  logic [FCW-1:0]     flush_cnt;
  logic [TWAW-1:0]    tw_q;

  r5_mod_counter #(.DEPTH(DEPTH)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (advance),
    .clr        (cnt_clr),
    .idx        (idx),
    .phase      (phase),
    .idx_wrap   (idx_wrap),
    .phase_wrap (phase_wrap)
  );

  assign flush_last = (flush_cnt == FCW'(FLUSH_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + FCW'(1) : '0;
    end
  end

  // rst_n gates advance so every strobe reads 0 while reset is held.
  always_comb begin
    advance   = 1'b0;
    cnt_clr   = 1'b0;
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        advance = bus.in_valid & rst_n;
        if (advance) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        advance = bus.in_valid & rst_n;
        if (advance && idx_wrap && phase == PHASE_W'(3)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        advance = bus.in_valid & rst_n;
        if (bus.flush) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        advance = rst_n;
        if (flush_last) begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef R5_SDF_CTRL_TW_EN
  localparam int TW_MOD = 5 * DEPTH;

  logic [TWAW:0] tw_sum;

  assign tw_sum = {1'b0, tw_q} + (TWAW + 1)'(phase);

  // Running phase*idx: one add per step, folded by 5*DEPTH, reset when idx returns to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_q <= '0;
    end else if (cnt_clr) begin
      tw_q <= '0;
    end else if (advance) begin
      if (idx_wrap)
        tw_q <= '0;
      else if (tw_sum >= (TWAW + 1)'(TW_MOD))
        tw_q <= TWAW'(tw_sum - (TWAW + 1)'(TW_MOD));
      else
        tw_q <= tw_sum[TWAW-1:0];
    end
  end
`else
  assign tw_q = '0;
`endif

  assign bus.shift_en  = advance;
  assign bus.bf_en     = advance & phase_wrap;
  assign bus.zero_ins  = (state == ST_FLUSH);
  assign bus.out_valid = advance & ((state == ST_RUN) | (state == ST_FLUSH));
  assign bus.busy      = (state != ST_IDLE);
  assign bus.phase     = phase;
  assign bus.idx       = idx;
  assign bus.tw_addr   = tw_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_r5_sdf_ctrl.sv
// Self-checking bench for r5_sdf_ctrl (DEPTH=25): sample-count model plus directed literal checks.
module tb_r5_sdf_ctrl;
  import r5_fft_pkg::*;

  localparam int D   = 25;
  localparam int TWM = 5 * D;
`ifdef R5_SDF_CTRL_TW_EN
  localparam bit TW_ON = 1'b1;
`else
  localparam bit TW_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [2:0] exp_q[$];

  r5_sdf_ctrl_if #(.DEPTH(D), .TWAW(7)) bus ();

  r5_sdf_ctrl #(.DEPTH(D), .TWAW(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endfunction

  // model: session mode (0 idle,1 fill,2 run,3 flush), accepted step count k, flush cycles
  int m_mode, m_k, m_fl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_k    <= 0;
      m_fl   <= 0;
    end else begin
      case (m_mode)
        0: if (bus.in_valid) begin
             m_mode <= 1;
             m_k    <= 1;
           end
        1: if (bus.in_valid) begin
             m_k <= m_k + 1;
             if (m_k + 1 == 4 * D) m_mode <= 2;
           end
        2: begin
             if (bus.in_valid) m_k <= m_k + 1;
             if (bus.flush) begin
               m_mode <= 3;
               m_fl   <= 0;
             end
           end
        default: begin
             m_k  <= m_k + 1;
             m_fl <= m_fl + 1;
             if (m_fl + 1 == 4 * D) begin
               m_mode <= 0;
               m_k    <= 0;
             end
           end
      endcase
    end
  end

  // compare process: every cycle, outputs against the model
  always @(negedge clk) begin
    bit adv;
    int ph, ix;
    adv = rst_n && (m_mode == 3 || bus.in_valid);
    ph  = (m_k / D) % 5;
    ix  = m_k % D;
    chk("m_shift_en",  int'(bus.shift_en),  int'(adv));
    chk("m_phase",     int'(bus.phase),     ph);
    chk("m_idx",       int'(bus.idx),       ix);
    chk("m_bf_en",     int'(bus.bf_en),     int'(adv && ph == 4));
    chk("m_zero_ins",  int'(bus.zero_ins),  int'(m_mode == 3));
    chk("m_out_valid", int'(bus.out_valid), int'(adv && m_mode >= 2));
    chk("m_busy",      int'(bus.busy),      int'(m_mode != 0));
    chk("m_tw_addr",   int'(bus.tw_addr),   TW_ON ? (ph * ix) % TWM : 0);
  end

  // driver: inputs change 1 after the edge, sampling happens at the next negedge
  task automatic step(input logic iv, input logic fl);
    @(posedge clk);
    #1;
    bus.in_valid = iv;
    bus.flush    = fl;
    @(negedge clk);
  endtask

  initial begin
    int bf_cnt, ov_cnt, fill_ov, a, z_cnt, fo_cnt;
    logic iv;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;

    // reset, with in_valid already high
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b1;
    @(negedge clk);
    chk("rst_shift_en",  int'(bus.shift_en),  0);
    chk("rst_bf_en",     int'(bus.bf_en),     0);
    chk("rst_zero_ins",  int'(bus.zero_ins),  0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy",      int'(bus.busy),      0);
    chk("rst_phase",     int'(bus.phase),     0);
    chk("rst_tw_addr",   int'(bus.tw_addr),   0);

    // startup + steady state: 250 consecutive samples, flush ignored during fill
    for (int p = 0; p < 4; p++) repeat (D) exp_q.push_back(3'(p));
    bf_cnt = 0; ov_cnt = 0; fill_ov = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 250; i++) begin
      if (i > 0) step(1'b1, i == 50);
      if (i < 100) begin
        if (exp_q.size() > 0) chk("phase_seq", int'(bus.phase), int'(exp_q.pop_front()));
        if (bus.out_valid) fill_ov++;
      end
      if (i == 100) chk("run_at_101", int'(bus.state), int'(ST_RUN));
      if (i >= 75 && i < 100) chk("tw_phase3", int'(bus.tw_addr), TW_ON ? (3 * (i - 75)) % TWM : 0);
      chk("bf_en_steady", int'(bus.bf_en), int'((i / D) % 5 == 4));
      chk("ov_steady", int'(bus.out_valid), int'(i >= 100));
      if (bus.bf_en) bf_cnt++;
      if (bus.out_valid) ov_cnt++;
    end
    chk("fill_ov_count", fill_ov, 0);
    chk("bf_count", bf_cnt, 50);
    chk("ov_count", ov_cnt, 150);
    chk("phase_q_empty", exp_q.size(), 0);

    // move into phase 1, then alternate in_valid
    repeat (D) step(1'b1, 1'b0);
    a = 0;
    for (int j = 0; j < 20; j++) begin
      iv = 1'(j % 2 == 0);
      step(iv, 1'b0);
      chk("gap_shift", int'(bus.shift_en), int'(iv));
      chk("gap_idx",   int'(bus.idx),      a);
      chk("gap_phase", int'(bus.phase),    1);
      chk("gap_tw",    int'(bus.tw_addr),  TW_ON ? a : 0);
      if (iv) a++;
    end

    // idle run holds everything
    repeat (D) begin
      step(1'b0, 1'b0);
      chk("hold_idx",   int'(bus.idx),      10);
      chk("hold_phase", int'(bus.phase),    1);
      chk("hold_tw",    int'(bus.tw_addr),  TW_ON ? 10 : 0);
      chk("hold_shift", int'(bus.shift_en), 0);
    end

    // flush together with a sample, in_valid random during the drain
    step(1'b1, 1'b1);
    chk("fl_accept_shift", int'(bus.shift_en),  1);
    chk("fl_accept_ov",    int'(bus.out_valid), 1);
    chk("fl_accept_zero",  int'(bus.zero_ins),  0);
    chk("fl_accept_idx",   int'(bus.idx),       10);
    z_cnt = 0; fo_cnt = 0;
    for (int j = 0; j < 100; j++) begin
      step(1'($urandom_range(0, 1)), 1'b0);
      if (bus.zero_ins) z_cnt++;
      if (bus.out_valid) fo_cnt++;
    end
    chk("flush_zero_count", z_cnt, 100);
    chk("flush_ov_count", fo_cnt, 100);
    step(1'b0, 1'b0);
    chk("post_flush_busy",  int'(bus.busy),     0);
    chk("post_flush_state", int'(bus.state),    int'(ST_IDLE));
    chk("post_flush_phase", int'(bus.phase),    0);
    chk("post_flush_idx",   int'(bus.idx),      0);
    chk("post_flush_zero",  int'(bus.zero_ins), 0);

    // reset in the middle of a flush
    repeat (110) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b0);
    chk("pre_rst_zero", int'(bus.zero_ins), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_shift", int'(bus.shift_en),  0);
    chk("mid_rst_bf",    int'(bus.bf_en),     0);
    chk("mid_rst_zero",  int'(bus.zero_ins),  0);
    chk("mid_rst_ov",    int'(bus.out_valid), 0);
    chk("mid_rst_busy",  int'(bus.busy),      0);
    chk("mid_rst_phase", int'(bus.phase),     0);
    chk("mid_rst_idx",   int'(bus.idx),       0);
    chk("mid_rst_tw",    int'(bus.tw_addr),   0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("restart_shift", int'(bus.shift_en), 1);
    chk("restart_phase", int'(bus.phase),    0);
    chk("restart_idx",   int'(bus.idx),      0);
    step(1'b1, 1'b0);
    chk("restart_idx1",  int'(bus.idx),      1);
    chk("restart_state", int'(bus.state),    int'(ST_FILL));
    repeat (3) step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
